tri_set_hit_tester: RTL

- Sequential, parametrised successor of the single-triangle point-in-triangle test.
- Holds a writable table of NUM_TRI triangles with signed COORD_W-bit vertices.
- Accepts query points over a valid/ready handshake and evaluates one triangle per cycle.
- Returns a hit mask, an any-hit flag and the lowest hit index. Sits between the coordinate generator and the pixel/colour stage.

---
 rtl/tri_set_hit_tester.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/tri_set_hit_tester.sv
// -----------------------------------------------------------------------------
// tri_set_hit_tester
//
// Purpose:
//   Sequential point-in-triangle tester over a writable table of NUM_TRI
//   triangles. A query point is accepted over a valid/ready handshake.
//   One triangle slot is evaluated per cycle. The block then presents a
//   per-slot hit mask, an any-hit flag and the lowest hit index until
//   downstream accepts the result.
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   wr_en / wr_ready      table write strobe / write accepted (not in EVAL)
//   wr_idx, wr_vtx        slot and vertex (0..2) to write; vertex 3 is dropped
//   wr_x, wr_y            signed vertex coordinates
//   wr_tri_en             slot enable, written with every vertex write
//   in_valid / in_ready   query handshake (ready only in IDLE)
//   px, py                signed query point
//   out_valid / out_ready result handshake
//   hit_mask              bit i set when the point lies inside slot i
//   any_hit               OR of hit_mask
//   first_idx             lowest set index of hit_mask, 0 when none
// -----------------------------------------------------------------------------
module tri_set_hit_tester #(
    parameter int COORD_W   = 12,
    parameter int NUM_TRI   = 4,
    parameter int IDX_W     = (NUM_TRI > 1) ? $clog2(NUM_TRI) : 1,
    parameter int INCLUSIVE = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    output logic                      wr_ready,
    input  logic [IDX_W-1:0]          wr_idx,
    input  logic [1:0]                wr_vtx,
    input  logic signed [COORD_W-1:0] wr_x,
    input  logic signed [COORD_W-1:0] wr_y,
    input  logic                      wr_tri_en,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [COORD_W-1:0] px,
    input  logic signed [COORD_W-1:0] py,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_TRI-1:0]        hit_mask,
    output logic                      any_hit,
    output logic [IDX_W-1:0]          first_idx
);

    // Full-precision intermediate types: no stage of the edge or area
    // arithmetic ever truncates.
    typedef logic signed [COORD_W:0]     diff_t;
    typedef logic signed [2*COORD_W+1:0] prod_t;
    typedef logic signed [2*COORD_W+2:0] edge_t;
    typedef logic signed [2*COORD_W+4:0] sum_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state_r;
    state_t                    state_n;

    logic signed [COORD_W-1:0] vx_r [NUM_TRI][3];
    logic signed [COORD_W-1:0] vy_r [NUM_TRI][3];
    logic [NUM_TRI-1:0]        tri_en_r;

    logic signed [COORD_W-1:0] px_r;
    logic signed [COORD_W-1:0] py_r;
    logic [IDX_W-1:0]          cnt_r;
    logic [NUM_TRI-1:0]        mask_acc_r;

    logic                      wr_fire_s;
    logic                      last_s;
    edge_t                     e0_s;
    edge_t                     e1_s;
    edge_t                     e2_s;
    sum_t                      area2_s;
    logic                      all_pos_s;
    logic                      all_neg_s;
    logic                      hit_s;
    logic [NUM_TRI-1:0]        mask_next_s;

    // e = (Px-Bx)*(Ay-By) - (Ax-Bx)*(Py-By) for the directed edge A->B.
    function automatic edge_t edge_fn(
        input logic signed [COORD_W-1:0] qx,
        input logic signed [COORD_W-1:0] qy,
        input logic signed [COORD_W-1:0] ax,
        input logic signed [COORD_W-1:0] ay,
        input logic signed [COORD_W-1:0] bx,
        input logic signed [COORD_W-1:0] by
    );
        diff_t dqx;
        diff_t day;
        diff_t dax;
        diff_t dqy;
        prod_t p0;
        prod_t p1;
        dqx = diff_t'(qx) - diff_t'(bx);
        day = diff_t'(ay) - diff_t'(by);
        dax = diff_t'(ax) - diff_t'(bx);
        dqy = diff_t'(qy) - diff_t'(by);
        p0  = prod_t'(dqx) * prod_t'(day);
        p1  = prod_t'(dax) * prod_t'(dqy);
        return edge_t'(p0) - edge_t'(p1);
    endfunction

    // Priority encoder: the lowest set bit wins, 0 when the mask is empty.
    function automatic logic [IDX_W-1:0] first_set(input logic [NUM_TRI-1:0] m);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = NUM_TRI - 1; i >= 0; i--) begin
            if (m[i]) begin
                r = IDX_W'(i);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Table write qualification: out-of-range slot or vertex 3 is dropped.
    always_comb begin
        wr_fire_s = 1'b0;
        if (wr_en && wr_ready && (wr_vtx != 2'd3) && (32'(wr_idx) < NUM_TRI)) begin
            wr_fire_s = 1'b1;
        end else begin
            wr_fire_s = 1'b0;
        end
    end

    // Triangle table storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_TRI; i++) begin
                for (int v = 0; v < 3; v++) begin
                    vx_r[i][v] <= '0;
                    vy_r[i][v] <= '0;
                end
            end
            tri_en_r <= '0;
        end else if (wr_fire_s) begin
            vx_r[wr_idx][wr_vtx] <= wr_x;
            vy_r[wr_idx][wr_vtx] <= wr_y;
            tri_en_r[wr_idx]     <= wr_tri_en;
        end
    end

    // Edge functions, doubled area and hit decision for slot cnt_r.
    always_comb begin
        e0_s = edge_fn(px_r, py_r, vx_r[cnt_r][0], vy_r[cnt_r][0], vx_r[cnt_r][1], vy_r[cnt_r][1]);
        e1_s = edge_fn(px_r, py_r, vx_r[cnt_r][1], vy_r[cnt_r][1], vx_r[cnt_r][2], vy_r[cnt_r][2]);
        e2_s = edge_fn(px_r, py_r, vx_r[cnt_r][2], vy_r[cnt_r][2], vx_r[cnt_r][0], vy_r[cnt_r][0]);
        area2_s = sum_t'(e0_s) + sum_t'(e1_s) + sum_t'(e2_s);
        // Both windings are accepted, so test "all same sign" both ways.
        if (INCLUSIVE != 0) begin
            all_pos_s = !e0_s[2*COORD_W+2] && !e1_s[2*COORD_W+2] && !e2_s[2*COORD_W+2];
            all_neg_s = (e0_s[2*COORD_W+2] || (e0_s == '0)) &&
                        (e1_s[2*COORD_W+2] || (e1_s == '0)) &&
                        (e2_s[2*COORD_W+2] || (e2_s == '0));
        end else begin
            all_pos_s = !e0_s[2*COORD_W+2] && (e0_s != '0) &&
                        !e1_s[2*COORD_W+2] && (e1_s != '0) &&
                        !e2_s[2*COORD_W+2] && (e2_s != '0);
            all_neg_s = e0_s[2*COORD_W+2] && e1_s[2*COORD_W+2] && e2_s[2*COORD_W+2];
        end
        // A zero-area triangle never hits, otherwise collinear vertices
        // would claim every point on their line in inclusive mode.
        hit_s = tri_en_r[cnt_r] && (area2_s != '0) && (all_pos_s || all_neg_s);
    end

    // Merge the current slot's hit bit into the accumulated mask.
    always_comb begin
        mask_next_s = mask_acc_r;
        for (int i = 0; i < NUM_TRI; i++) begin
            if (32'(cnt_r) == i) begin
                mask_next_s[i] = hit_s;
            end else begin
                mask_next_s[i] = mask_acc_r[i];
            end
        end
        last_s = (cnt_r == IDX_W'(NUM_TRI - 1));
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_n = EVAL;
                end else begin
                    state_n = IDLE;
                end
            end
            EVAL: begin
                if (last_s) begin
                    state_n = DONE;
                end else begin
                    state_n = EVAL;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_n = IDLE;
                end else begin
                    state_n = DONE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Query datapath and registered outputs; handshake flags are decoded
    // from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            px_r       <= '0;
            py_r       <= '0;
            cnt_r      <= '0;
            mask_acc_r <= '0;
            hit_mask   <= '0;
            any_hit    <= 1'b0;
            first_idx  <= '0;
            out_valid  <= 1'b0;
            in_ready   <= 1'b1;
            wr_ready   <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        px_r       <= px;
                        py_r       <= py;
                        cnt_r      <= '0;
                        mask_acc_r <= '0;
                    end
                end
                EVAL: begin
                    mask_acc_r <= mask_next_s;
                    if (last_s) begin
                        hit_mask  <= mask_next_s;
                        any_hit   <= |mask_next_s;
                        first_idx <= first_set(mask_next_s);
                    end else begin
                        cnt_r <= cnt_r + IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
            out_valid <= (state_n == DONE);
            in_ready  <= (state_n == IDLE);
            wr_ready  <= (state_n != EVAL);
        end
    end

endmodule
